// File: rtl/fft_pkg.sv
// Shared types and butterfly address helper for the radix-2 DIT FFT stage sequencer.
// The address function is also used by verification models.
package fft_pkg;

   localparam int unsigned LOG2_N_DEF = 8;
   localparam int unsigned LOG2_N_MAX = 12;

   typedef enum logic [1:0] {IDLE, RUN, GAP} seq_state_t;

   typedef struct packed {
      logic [LOG2_N_MAX-1:0] addr_a;
      logic [LOG2_N_MAX-1:0] addr_b;
      logic [LOG2_N_MAX-2:0] tw_addr;
   } bfly_addr_t;

   // Upper/lower leg and twiddle index for butterfly j of stage s, sized for the largest FFT.
   function automatic bfly_addr_t bfly_addr(input int unsigned log2n,
                                            input int unsigned s,
                                            input int unsigned j);
      bfly_addr_t  r;
      int unsigned half;
      int unsigned grp;
      int unsigned pos;
      int unsigned a;
      half      = 32'd1 << s;
      grp       = j >> s;
      pos       = j & (half - 32'd1);
      a         = (grp << (s + 32'd1)) | pos;
      r.addr_a  = LOG2_N_MAX'(a);
      r.addr_b  = LOG2_N_MAX'(a + half);
      r.tw_addr = (LOG2_N_MAX-1)'(pos << (log2n - 32'd1 - s));
      return r;
   endfunction

endpackage

// File: rtl/sync_flex_counter.sv
// Up-counter with synchronous reset/clear, enable and a programmable rollover value.
// wrap_c flags the enabled cycle in which the counter returns to zero.
module sync_flex_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] roll_val,
   output logic [W-1:0] count,
   output logic         wrap_c
);

   assign wrap_c = en && (count == roll_val);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (en) begin
         count <= wrap_c ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences butterflies and stages of a 2^LOG2_N point radix-2 DIT FFT, generating
// data-pair and twiddle addresses and a pipeline-drain gap between stages.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned LOG2_N     = LOG2_N_DEF,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned STAGE_W    = (LOG2_N > 2) ? $clog2(LOG2_N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               clear,
   input  logic               bfly_advance,
   output logic               issue_ok,
   output logic               busy,
   output logic [STAGE_W-1:0] stage_count,
   output logic [LOG2_N-2:0]  bfly_count,
   output logic [LOG2_N-1:0]  addr_a,
   output logic [LOG2_N-1:0]  addr_b,
   output logic [LOG2_N-2:0]  tw_addr,
   output logic               stage_done,
   output logic               fft_done
);

   localparam int unsigned BW = LOG2_N - 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2_N - 1);
   localparam logic [GW-1:0]      GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_state_t         state;
   seq_state_t         next_state;
   logic [STAGE_W-1:0] stage_next;
   logic               stage_done_next;
   logic               fft_done_next;
   logic               bfly_en;
   logic               bfly_wrap_c;
   logic               gap_en;
   logic               gap_wrap_c;
   logic [GW-1:0]      gap_count_unused;
   bfly_addr_t         addr_c;

   assign bfly_en = (state == RUN) && bfly_advance;
   assign gap_en  = (state == GAP);

   sync_flex_counter #(.W(BW)) u_bfly_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .en       (bfly_en),
      .roll_val ('1),
      .count    (bfly_count),
      .wrap_c   (bfly_wrap_c)
   );

   sync_flex_counter #(.W(GW)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .en       (gap_en),
      .roll_val (GAP_LAST),
      .count    (gap_count_unused),
      .wrap_c   (gap_wrap_c)
   );

   // Next state, stage index and completion pulses.
   always_comb begin
      next_state      = state;
      stage_next      = stage_count;
      stage_done_next = 1'b0;
      fft_done_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               stage_next = '0;
            end
         end
         RUN: begin
            if (bfly_wrap_c) begin
               stage_done_next = 1'b1;
               if (stage_count == LAST_STAGE) begin
                  fft_done_next = 1'b1;
                  stage_next    = '0;
                  next_state    = IDLE;
               end else begin
                  stage_next = stage_count + STAGE_W'(1);
                  next_state = (GAP_CYCLES == 0) ? RUN : GAP;
               end
            end
         end
         GAP: begin
            if (gap_wrap_c) begin
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // issue_ok/busy are registered from the next state so they track state exactly.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state       <= IDLE;
         stage_count <= '0;
         issue_ok    <= 1'b0;
         busy        <= 1'b0;
         stage_done  <= 1'b0;
         fft_done    <= 1'b0;
      end else begin
         state       <= next_state;
         stage_count <= stage_next;
         issue_ok    <= (next_state == RUN);
         busy        <= (next_state != IDLE);
         stage_done  <= stage_done_next;
         fft_done    <= fft_done_next;
      end
   end

   assign addr_c  = bfly_addr(LOG2_N, 32'(stage_count), 32'(bfly_count));
   assign addr_a  = LOG2_N'(addr_c.addr_a);
   assign addr_b  = LOG2_N'(addr_c.addr_b);
   assign tw_addr = (LOG2_N-1)'(addr_c.tw_addr);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized self-checking bench for fft_stage_sequencer across three parameter sets,
// compared against a transform-level model of butterfly order, gaps and addresses.
module tb_fft_stage_sequencer;

   logic clk;
   logic reset;
   logic start_v[3];
   logic clear_v[3];
   logic adv_v[3];
   logic iok[3];
   logic bsy[3];
   logic sd[3];
   logic fd[3];
   logic [11:0] sc[3];
   logic [11:0] bc[3];
   logic [11:0] oa[3];
   logic [11:0] ob[3];
   logic [11:0] ot[3];

   logic [1:0] sc0;
   logic [1:0] bc0;
   logic [2:0] a0;
   logic [2:0] b0;
   logic [1:0] t0;
   logic [2:0] sc1;
   logic [6:0] bc1;
   logic [7:0] a1;
   logic [7:0] b1;
   logic [6:0] t1;
   logic [1:0] sc2;
   logic [2:0] bc2;
   logic [3:0] a2;
   logic [3:0] b2;
   logic [2:0] t2;

   int lk[3] = '{3, 8, 4};
   int gk[3] = '{0, 2, 1};
   int a3_exp[3] = '{6, 5, 3};
   int t3_exp[3] = '{0, 2, 3};

   int checks = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fft_stage_sequencer #(.LOG2_N(3), .GAP_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .clear(clear_v[0]),
      .bfly_advance(adv_v[0]), .issue_ok(iok[0]), .busy(bsy[0]),
      .stage_count(sc0), .bfly_count(bc0), .addr_a(a0), .addr_b(b0),
      .tw_addr(t0), .stage_done(sd[0]), .fft_done(fd[0]));

   fft_stage_sequencer #(.LOG2_N(8), .GAP_CYCLES(2)) u1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .clear(clear_v[1]),
      .bfly_advance(adv_v[1]), .issue_ok(iok[1]), .busy(bsy[1]),
      .stage_count(sc1), .bfly_count(bc1), .addr_a(a1), .addr_b(b1),
      .tw_addr(t1), .stage_done(sd[1]), .fft_done(fd[1]));

   fft_stage_sequencer #(.LOG2_N(4), .GAP_CYCLES(1)) u2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .clear(clear_v[2]),
      .bfly_advance(adv_v[2]), .issue_ok(iok[2]), .busy(bsy[2]),
      .stage_count(sc2), .bfly_count(bc2), .addr_a(a2), .addr_b(b2),
      .tw_addr(t2), .stage_done(sd[2]), .fft_done(fd[2]));

   assign sc[0] = 12'(sc0);
   assign bc[0] = 12'(bc0);
   assign oa[0] = 12'(a0);
   assign ob[0] = 12'(b0);
   assign ot[0] = 12'(t0);
   assign sc[1] = 12'(sc1);
   assign bc[1] = 12'(bc1);
   assign oa[1] = 12'(a1);
   assign ob[1] = 12'(b1);
   assign ot[1] = 12'(t1);
   assign sc[2] = 12'(sc2);
   assign bc[2] = 12'(bc2);
   assign oa[2] = 12'(a2);
   assign ob[2] = 12'(b2);
   assign ot[2] = 12'(t2);

   function automatic string tg(input int k, input string name);
      return $sformatf("u%0d_%s", k, name);
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected addresses: insert a zero bit at position s of j; twiddle stride is N/2/half.
   task automatic check_outputs(input int k, input int s, input int j, input int running,
                                input int ingap, input int esd, input int efd);
      int nh;
      int half;
      int ea;
      nh   = 1 << (lk[k] - 1);
      half = 1 << s;
      ea   = j + ((j >> s) << s);
      check_eq(tg(k, "issue_ok"),   int'(iok[k]), int'(running != 0 && ingap == 0));
      check_eq(tg(k, "busy"),       int'(bsy[k]), running);
      check_eq(tg(k, "stage"),      int'(sc[k]), s);
      check_eq(tg(k, "bfly"),       int'(bc[k]), j);
      check_eq(tg(k, "addr_a"),     int'(oa[k]), ea);
      check_eq(tg(k, "addr_b"),     int'(ob[k]), ea + half);
      check_eq(tg(k, "tw_addr"),    int'(ot[k]), (j % half) * (nh / half));
      check_eq(tg(k, "stage_done"), int'(sd[k]), esd);
      check_eq(tg(k, "fft_done"),   int'(fd[k]), efd);
   endtask

   task automatic run_fft(input int k, input int duty, input int abort_s, input int abort_j);
      int L;
      int G;
      int nh;
      int n;
      int gleft;
      int acc;
      int s;
      int j;
      int running;
      int ingap;
      int esd;
      int efd;
      int finished;
      bit a;
      fft_pkg::bfly_addr_t r;
      L  = lk[k];
      G  = gk[k];
      nh = 1 << (L - 1);

      // Advance while idle must be ignored.
      adv_v[k] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_outputs(k, 0, 0, 0, 0, 0, 0);
      end
      adv_v[k]   = 1'b0;
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;

      n = 0; running = 1; ingap = 0; esd = 0; efd = 0; acc = 0; gleft = 0; finished = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         s = (running != 0) ? n / nh : 0;
         j = (running != 0) ? n % nh : 0;
         check_outputs(k, s, j, running, ingap, esd, efd);
         if (k == 0 && running != 0 && ingap == 0 && j == 3) begin
            check_eq(tg(k, "fixed_a"),  int'(oa[0]), a3_exp[s]);
            check_eq(tg(k, "fixed_b"),  int'(ob[0]), 7);
            check_eq(tg(k, "fixed_tw"), int'(ot[0]), t3_exp[s]);
         end
         if (k == 2) begin
            r = fft_pkg::bfly_addr(4, s, j);
            check_eq(tg(k, "pkg_a"),  int'(oa[2]), int'(r.addr_a));
            check_eq(tg(k, "pkg_tw"), int'(ot[2]), int'(r.tw_addr));
         end
         if (running == 0) begin
            adv_v[k]   = 1'b0;
            start_v[k] = 1'b0;
            check_eq(tg(k, "accepted"), acc, L * nh);
            if (duty == 100) check_eq(tg(k, "done_cycle"), cyc, L * nh + (L - 1) * G);
            finished = 1;
            break;
         end
         if (ingap == 0 && s == abort_s && j == abort_j) begin
            clear_v[k] = 1'b1;
            adv_v[k]   = 1'b1;
            start_v[k] = 1'b0;
            @(negedge clk);
            clear_v[k] = 1'b0;
            adv_v[k]   = 1'b0;
            check_outputs(k, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check_outputs(k, 0, 0, 0, 0, 0, 0);
            finished = 1;
            break;
         end
         a          = ($urandom_range(99) < duty);
         adv_v[k]   = a;
         start_v[k] = 1'($urandom_range(1));
         if (a && iok[k]) acc++;
         esd = 0;
         efd = 0;
         if (ingap != 0) begin
            gleft--;
            if (gleft == 0) ingap = 0;
         end else if (a) begin
            n++;
            if (n % nh == 0) begin
               esd = 1;
               if (n == L * nh) begin
                  efd = 1;
                  running = 0;
               end else if (G > 0) begin
                  ingap = 1;
                  gleft = G;
               end
            end
         end
         @(negedge clk);
      end
      if (finished == 0) begin
         adv_v[k]   = 1'b0;
         start_v[k] = 1'b0;
         check_eq(tg(k, "timeout"), 0, 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         clear_v[k] = 1'b0;
         adv_v[k]   = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_outputs(k, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      @(negedge clk);
      run_fft(0, 100, -1, -1);
      run_fft(1, 100, -1, -1);
      run_fft(1, 100, 2, 17);
      run_fft(1, 100, -1, -1);
      run_fft(2, 50, -1, -1);
      run_fft(2, 50, -1, -1);
      run_fft(0, 70, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Parametrised successor to the fixed 256-point stage counter. Sequences a radix-2 DIT FFT of N = 2^LOG2_N points by counting butterflies within each stage and stages within the transform. Generates the per-butterfly data-pair and twiddle addresses, and inserts a programmable pipeline-drain gap between stages. Sits between the FFT control FSM (start/clear) and the butterfly datapath / sample RAM.

Parameters:
LOG2_N, 8, log2 of FFT length; legal range 2..12; 8 gives 256 points and 8 stages.
GAP_CYCLES, 2, idle cycles inserted between stages for butterfly pipeline drain; 0 is legal.
STAGE_W, $clog2(LOG2_N) (minimum 1), derived width of the stage index; not for override.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a transform; honoured only in IDLE
clear  in  1  synchronous abort; same effect as reset
bfly_advance  in  1  one butterfly issued this cycle; honoured only when issue_ok=1
issue_ok  out  1  high in RUN; datapath may issue a butterfly
busy  out  1  high in RUN or GAP
stage_count  out  STAGE_W  current stage s, 0..LOG2_N-1
bfly_count  out  LOG2_N-1  butterfly index j within stage, 0..N/2-1
addr_a  out  LOG2_N  upper-leg sample address
addr_b  out  LOG2_N  lower-leg sample address
tw_addr  out  LOG2_N-1  twiddle ROM index
stage_done  out  1  one-cycle pulse after the last butterfly of any stage is accepted
fft_done  out  1  one-cycle pulse after the last butterfly of the last stage is accepted

Behaviour:
- Reset or clear: state=IDLE; stage_count=0; bfly_count=0; gap counter=0; all pulses=0; issue_ok=0; busy=0. clear has priority over start and bfly_advance in the same cycle.
- States:
  - IDLE: start=1 -> RUN on the next cycle, with counters at 0.
  - RUN: counts accepted butterflies. See the RUN rules below.
  - GAP: counts GAP_CYCLES cycles, then -> RUN.
- RUN rules:
  - Accepted advance with j < N/2-1: j++.
  - Accepted advance with j = N/2-1 and s < LOG2_N-1: j=0, s++. Next state is GAP, or RUN directly if GAP_CYCLES=0.
  - Accepted advance with j = N/2-1 and s = LOG2_N-1: j=0, s=0, -> IDLE.
- Pulses are registered. stage_done=1 in the cycle after the accepting edge. On the final stage, fft_done=1 in that same cycle.
- Ignored inputs: start while busy; bfly_advance while issue_ok=0 (no count change).
- Addresses are combinational from the registered s and j. With half = 2^s, grp = j>>s, pos = j & (half-1):
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + half
  - tw_addr = pos << (LOG2_N-1-s)
  - All are unsigned, truncated to port width, and never overflow for legal s.
- Throughput: one butterfly per cycle sustained in RUN. The first issue_ok cycle is the cycle after start.
- Reset or clear mid-transform: abort immediately; no stage_done or fft_done pulse is emitted.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum {IDLE, RUN, GAP}
  - the LOG2_N default constant
  - a pure function computing {addr_a, addr_b, tw_addr} from (s, j), shared with the verification model.
- One sub-module, sync_flex_counter: parametrised width, synchronous active-high reset, clear, enable, rollover value, and a rollover flag.
  - Instantiate it once for bfly_count (rollover N/2-1).
  - Instantiate it once for the gap counter.
  - The stage counter stays in the FSM because of the last-stage special case.

Test Plan:
- LOG2_N=3, GAP_CYCLES=0, start then bfly_advance held at 1 -> stage_done pulses after the 4th, 8th and 12th advances; fft_done coincides with the third stage_done; busy falls in the same cycle.
- LOG2_N=3, check addresses at j=3 -> s=0: a=6, b=7, tw=0; s=1: a=5, b=7, tw=2; s=2: a=3, b=7, tw=3.
- LOG2_N=8, GAP_CYCLES=2, advance every issue_ok cycle -> fft_done exactly 1038 cycles after the first issue_ok cycle (1024 butterflies + 7×2 gap cycles); issue_ok=0 in every gap cycle.
- Advance asserted in IDLE and during GAP, and start asserted mid-RUN -> no change to counters or state.
- clear asserted at s=2, j=17, together with bfly_advance=1 -> next cycle IDLE, all outputs 0, no done pulse; a subsequent start restarts from s=0, j=0.
- Random bfly_advance gaps (50% duty) with LOG2_N=4 -> scoreboard addresses match fft_pkg function output; exactly 32 accepted advances precede fft_done.
